// File: rtl/prog_loader.sv
// Byte-stream instruction-memory loader: parses LEN/payload/CSUM frames,
// writes 32-bit words to imem and holds the CPU in reset while loading.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]    r_state;
    logic [7:0]    r_len_lo;
    logic [15:0]   r_len;
    logic [7:0]    r_csum;
    logic [1:0]    r_bcnt;
    logic [ADDR_W:0] r_waddr;
    logic [23:0]   r_sr;

    logic [2:0]    w_next;
    logic          w_xfer;
    logic          w_start;
    logic [15:0]   w_len;
    logic          w_len_ok;
    logic          w_last;
    logic          w_err_next;

    always_comb begin
        w_xfer   = byte_valid & byte_ready;
        w_start  = start && (r_state == S_IDLE);
        w_len    = {byte_data, r_len_lo};
        w_len_ok = (32'(w_len) >= 32'd1) && (32'(w_len) <= 32'(MAX_WORDS));
        // Last byte of the final word: the word index counter is one wider than the address
        w_last   = (r_bcnt == 2'd3) && ((32'(r_waddr) + 32'd1) == 32'(r_len));

        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)  w_next = S_LEN0;
            S_LEN0: if (w_xfer) w_next = S_LEN1;
            S_LEN1: if (w_xfer) w_next = w_len_ok ? S_DATA : S_ERR;
            S_DATA: if (w_xfer && w_last) w_next = S_CSUM;
            S_CSUM: if (w_xfer) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
            S_DONE: w_next = S_IDLE;
            S_ERR:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_err_next = (w_next == S_ERR) || (err && !w_start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_csum     <= '0;
            r_bcnt     <= '0;
            r_waddr    <= '0;
            r_sr       <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_next;
            byte_ready <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                          (w_next == S_DATA) || (w_next == S_CSUM);
            busy       <= (w_next != S_IDLE);
            done       <= (w_next == S_DONE);
            err        <= w_err_next;
            // CPU stays in reset while loading and after a failed load
            cpu_rst    <= (w_next != S_IDLE) || w_err_next;
            imem_we    <= 1'b0;

            if (w_start) begin
                r_csum  <= '0;
                r_bcnt  <= '0;
                r_waddr <= '0;
            end

            if (w_xfer) begin
                case (r_state)
                    S_LEN0: begin
                        r_len_lo <= byte_data;
                        r_csum   <= r_csum + byte_data;
                    end
                    S_LEN1: begin
                        r_len  <= w_len;
                        r_csum <= r_csum + byte_data;
                    end
                    S_DATA: begin
                        r_csum <= r_csum + byte_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_waddr[ADDR_W-1:0];
                            imem_wdata <= {byte_data, r_sr};
                            r_waddr    <= r_waddr + 1'b1;
                        end else begin
                            r_sr <= {byte_data, r_sr[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle table for single-word sessions,
// hand sequences for gapped multi-word load and mid-session reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // {byte_ready, busy, done, err, cpu_rst}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_IDLEE = 5'b00011;
    localparam logic [4:0] F_RUN   = 5'b11001;
    localparam logic [4:0] F_DONE  = 5'b01101;
    localparam logic [4:0] F_ERR   = 5'b01011;
    localparam logic [4:0] F_RST   = 5'b00001;

    typedef struct {
        logic        st;
        logic        bv;
        logic [7:0]  bd;
        logic [45:0] exp;
    } row_t;

    row_t rows[$];

    int checks   = 0;
    int failures = 0;

    int          n_wr = 0;
    logic [7:0]  wr_addr[0:63];
    logic [31:0] wr_data[0:63];

    always @(negedge clk) begin
        if (imem_we && n_wr < 64) begin
            wr_addr[n_wr] = imem_addr;
            wr_data[n_wr] = imem_wdata;
            n_wr = n_wr + 1;
        end
    end

    function automatic logic [45:0] obs();
        return {imem_we, imem_addr, imem_wdata, byte_ready, busy, done, err, cpu_rst};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic add(input logic st, input logic bv, input logic [7:0] bd,
                       input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [4:0] f);
        row_t r;
        r.st  = st;
        r.bv  = bv;
        r.bd  = bd;
        r.exp = {we, a, d, f};
        rows.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic bv, input logic [7:0] bd);
        start      = st;
        byte_valid = bv;
        byte_data  = bd;
    endtask

    // Sends one byte after `gap` idle cycles; flags any cycle where the loader is not ready
    task automatic send(input logic [7:0] b, input int gap, inout int not_ready);
        for (int g = 0; g < gap; g++) begin
            if (byte_ready !== 1'b1) not_ready = not_ready + 1;
            drive(1'b0, 1'b0, 8'h00);
            step();
        end
        if (byte_ready !== 1'b1) not_ready = not_ready + 1;
        drive(1'b0, 1'b1, b);
        step();
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int nr;
        int w0;
        logic [7:0] s3 [0:14];
        logic [7:0] s2 [0:4];
        logic [7:0] s1 [0:6];

        // One-word good load: 0x00500093, checksum E4
        add(1,0,8'h00, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h01, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h93, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h50, 0,8'h00,32'h0,        F_RUN);
        add(0,1,8'h00, 1,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hE4, 0,8'h00,32'h00500093, F_DONE);
        add(0,0,8'h00, 0,8'h00,32'h00500093, F_IDLE);
        // Same stream with bad checksum E5: write still happens, err sticks
        add(1,0,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h01, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h93, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h50, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 1,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hE5, 0,8'h00,32'h00500093, F_ERR);
        add(0,0,8'h00, 0,8'h00,32'h00500093, F_IDLEE);
        add(0,1,8'h55, 0,8'h00,32'h00500093, F_IDLEE);
        // Length 0x0101: start with a byte in IDLE (ignored), start in LEN0 (ignored)
        add(1,1,8'h77, 0,8'h00,32'h00500093, F_RUN);
        add(1,1,8'h01, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h01, 0,8'h00,32'h00500093, F_ERR);
        add(0,0,8'h00, 0,8'h00,32'h00500093, F_IDLEE);
        // Length 0x0000
        add(1,0,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h00500093, F_ERR);
        add(0,0,8'h00, 0,8'h00,32'h00500093, F_IDLEE);
        // Good load 0xDEADBEEF (checksum 39) clears err and releases the CPU
        add(1,0,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h01, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'h00, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hEF, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hBE, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hAD, 0,8'h00,32'h00500093, F_RUN);
        add(0,1,8'hDE, 1,8'h00,32'hDEADBEEF, F_RUN);
        add(0,1,8'h39, 0,8'h00,32'hDEADBEEF, F_DONE);
        add(0,0,8'h00, 0,8'h00,32'hDEADBEEF, F_IDLE);

        // Reset behaviour
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("reset_outputs", 64'(obs()), 64'({1'b0, 8'h00, 32'h0, F_RST}));
        rst = 1'b0;
        step();
        chk("post_reset_idle", 64'(obs()), 64'({1'b0, 8'h00, 32'h0, F_IDLE}));

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].st, rows[i].bv, rows[i].bd);
            step();
            if (obs() !== rows[i].exp)
                $display("row %0d outputs {we,addr,wdata,rdy,busy,done,err,cpu_rst}", i);
            chk($sformatf("table_row%0d", i), 64'(obs()), 64'(rows[i].exp));
        end
        drive(1'b0, 1'b0, 8'h00);

        // Three-word load of 0x00000013 with byte_valid gaps, checksum 3C
        s3 = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h3C};
        n_wr = 0;
        nr   = 0;
        drive(1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) send(s3[i], (i * 7 + 3) % 3, nr);
        chk("w3_done", 64'(done), 64'd1);
        chk("w3_ready_stays_high", 64'(nr), 64'd0);
        step();
        chk("w3_cpu_released", 64'({busy, cpu_rst, err}), 64'd0);
        chk("w3_write_count", 64'(n_wr), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < n_wr) begin
                chk($sformatf("w3_addr%0d", i), 64'(wr_addr[i]), 64'(i));
                chk($sformatf("w3_data%0d", i), 64'(wr_data[i]), 64'h13);
            end
        end

        // Reset after 5 payload bytes of a 2-word load
        s2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        n_wr = 0;
        drive(1'b1, 1'b0, 8'h00);
        step();
        send(8'h02, 0, nr);
        send(8'h00, 0, nr);
        for (int i = 0; i < 5; i++) send(s2[i], 0, nr);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h66);
        step();
        chk("midrst_outputs", 64'(obs()), 64'({1'b0, 8'h00, 32'h0, F_RST}));
        drive(1'b0, 1'b1, 8'h77);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("midrst_write_count", 64'(n_wr), 64'd1);
        chk("midrst_write0", 64'({wr_addr[0], wr_data[0]}), 64'({8'h00, 32'h44332211}));
        chk("midrst_idle", 64'(obs()), 64'({1'b0, 8'h00, 32'h0, F_IDLE}));

        // Fresh start restarts at address 0: 0x00500093 again
        s1 = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE4};
        n_wr = 0;
        w0   = 0;
        drive(1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) send(s1[i], 0, nr);
        for (int c = 0; c < 10 && done !== 1'b1; c++) begin
            step();
            w0 = w0 + 1;
        end
        chk("restart_done", 64'(done), 64'd1);
        chk("restart_write", 64'({n_wr[7:0], wr_addr[0], wr_data[0]}),
            64'({8'd1, 8'h00, 32'h00500093}));
        chk("restart_latency", 64'(w0), 64'd0);
        step();
        chk("restart_cpu_released", 64'(cpu_rst), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Streaming instruction-memory writer that fills the CPU's instruction memory from a byte stream (e.g. a UART receiver) and holds the CPU in reset while it does so. It is the producer side of instruction fetch: the CPU reads instruction words and this block writes them. It sits beside the `cpu` top, drives the instruction-memory write port, and owns the CPU reset.

## Interface
- `ADDR_W`, 8, word-address width of instruction memory.
- `MAX_WORDS`, 256, largest legal word count per load; must be ≤ 2^ADDR_W.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load session.
- `byte_valid`  in  1  input byte present.
- `byte_data`  in  8  input byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer happens when `byte_valid & byte_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  word to write.
- `cpu_rst`  out  1  reset for the `cpu` block.
- `busy`  out  1  load session in progress.
- `done`  out  1  one-cycle pulse on a successful load.
- `err`  out  1  sticky error flag, cleared by the next accepted `start`.

## Operation
- Stream format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - N×4 payload bytes, each word little-endian (byte 0 = bits 7:0).
  - CSUM: the 8-bit modular sum of all LEN and payload bytes.
- States:
  - IDLE → LEN0 on `start`. This clears `err`, the checksum, the byte counter and the word address.
  - LEN0 → LEN1 on a transfer.
  - LEN1 → DATA on a transfer when 1 ≤ N ≤ MAX_WORDS. Otherwise LEN1 → ERR.
  - DATA: collects bytes into a 32-bit shift register. On the 4th byte of a word it issues a write. After the write of word N−1 it moves to CSUM.
  - CSUM → DONE when the received byte equals the running sum. Otherwise CSUM → ERR.
  - DONE → IDLE after 1 cycle, with `done`=1 for that cycle.
  - ERR → IDLE after 1 cycle. `err` is set in that cycle and stays set.
- `byte_ready`=1 only in LEN0, LEN1, DATA and CSUM. There is no backpressure inside a state, so throughput is 1 byte/cycle.
- `busy`=1 in every state except IDLE.
- `cpu_rst`=1 in every state except IDLE, and also in IDLE while `err`=1. The CPU therefore never runs from a partially or badly loaded image.
- Writes use addresses 0,1,…,N−1 in order. The address counter is ADDR_W+1 bits wide internally, so N=MAX_WORDS=2^ADDR_W does not wrap before the length check completes.
- The checksum register is 8 bits and wraps mod 256.
- `start` outside IDLE is ignored.
- `byte_valid` in IDLE, DONE or ERR: the byte is not accepted and is not counted.

## Timing
- All outputs are registered.
- Reset values:
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0.
  - `cpu_rst`=1.
  - State = IDLE.
- First cycle after `rst` falls: `cpu_rst`=0, because the CPU runs the preloaded image.
- `start` at cycle t → `busy`=`cpu_rst`=`byte_ready`=1 at t+1.
- Write latency: the 4th byte of a word transfers at cycle t → `imem_we`=1 at t+1 with the assembled `imem_wdata` and `imem_addr`. Otherwise `imem_we`=0. `imem_addr`/`imem_wdata` hold their last values.
- CSUM byte transfers at t:
  - Match: `done`=1 at t+1; `busy`=0 and `cpu_rst`=0 at t+2.
  - Mismatch: `err`=1 at t+1; `busy`=0 at t+2; `cpu_rst` stays 1.
- `rst` mid-session: abort on that edge, return all outputs to reset values, issue no further `imem_we`. Already-written words are not rolled back.

## Test plan
- Reset, then idle: `cpu_rst`=1 during `rst` and 0 one cycle after it falls; all other outputs are 0.
- One-word load: `start`, then bytes 01 00 93 00 50 00 E4 back-to-back → exactly one `imem_we` with addr 0 and data 0x00500093; `done` pulses one cycle after the E4 byte; `cpu_rst` falls one cycle later.
- Three-word load with random `byte_valid` gaps: 0x00000013 ×3 → writes at addr 0, 1, 2 in order; `byte_ready` never drops inside the session; `done`=1 with the correct checksum.
- Same one-word stream but CSUM=E5 → the write at addr 0 still occurs; `err`=1; `done` never asserts; `cpu_rst` stays 1 until the next successful load.
- Length 0x0101 (>256) and length 0x0000 → ERR immediately after LEN_HI; no `imem_we`; `err`=1. A following `start` clears `err`.
- Assert `rst` after 5 payload bytes of a 2-word load → exactly one write (addr 0) occurred, no further writes, all outputs at reset values; a new `start` restarts cleanly from addr 0.
